// File: rtl/bp_cfg_sequencer.sv
// Boot-time configuration sequencer. After a start pulse it walks every core
// in order and, for each one, freezes the core, puts its CCE into uncached
// mode, copies the CCE microcode from a synchronous ROM into the CCE
// instruction RAM, restores normal CCE mode and unfreezes the core.
// All outputs are decoded from the registered state, so they are already
// zero in the cycle after a reset. They also hold steady while the cfg
// sink stalls.
module bp_cfg_sequencer #(
    parameter int num_core_p              = 1,
    parameter int cfg_core_width_p        = 8,
    parameter int cfg_addr_width_p        = 16,
    parameter int cfg_data_width_p        = 32,
    parameter int num_cce_instr_ram_els_p = 256,
    parameter int cce_instr_width_p       = 64,
    localparam int idx_w  = (num_cce_instr_ram_els_p > 1) ? $clog2(num_cce_instr_ram_els_p) : 1,
    localparam int core_w = (num_core_p > 1) ? $clog2(num_core_p) : 1
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         start_i,

    output logic                         rom_v_o,
    output logic [idx_w-1:0]             rom_addr_o,
    input  logic [cce_instr_width_p-1:0] rom_data_i,

    output logic                         cfg_v_o,
    output logic [cfg_core_width_p-1:0]  cfg_core_o,
    output logic [cfg_addr_width_p-1:0]  cfg_addr_o,
    output logic [cfg_data_width_p-1:0]  cfg_data_o,
    input  logic                         cfg_ready_i,

    output logic                         busy_o,
    output logic                         done_o
);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_FREEZE    = 4'd1;
    localparam logic [3:0] S_MODE_UC   = 4'd2;
    localparam logic [3:0] S_ROM_RD    = 4'd3;
    localparam logic [3:0] S_ROM_CAP   = 4'd4;
    localparam logic [3:0] S_WR_LO     = 4'd5;
    localparam logic [3:0] S_WR_HI     = 4'd6;
    localparam logic [3:0] S_MODE_NORM = 4'd7;
    localparam logic [3:0] S_UNFREEZE  = 4'd8;
    localparam logic [3:0] S_DONE      = 4'd9;

    localparam logic [cfg_addr_width_p-1:0] ADDR_FREEZE = cfg_addr_width_p'(16'h0001);
    localparam logic [cfg_addr_width_p-1:0] ADDR_MODE   = cfg_addr_width_p'(16'h0002);
    localparam logic [cfg_addr_width_p-1:0] ADDR_INSTR  = cfg_addr_width_p'(16'h8000);

    localparam logic [idx_w-1:0]  IDX_LAST  = idx_w'(num_cce_instr_ram_els_p - 1);
    localparam logic [core_w-1:0] CORE_LAST = core_w'(num_core_p - 1);

    localparam logic [cfg_data_width_p-1:0] DATA_ONE = cfg_data_width_p'(1);

    logic [3:0]                   state_r;
    logic [core_w-1:0]            core_r;
    logic [idx_w-1:0]             idx_r;
    logic [cce_instr_width_p-1:0] instr_r;
    logic                         hs;

    // A cfg write retires only when valid and ready meet.
    assign hs = cfg_v_o & cfg_ready_i;

    // Sequencer state, core/entry counters and captured microcode word.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= S_IDLE;
            core_r  <= '0;
            idx_r   <= '0;
            instr_r <= '0;
        end else begin
            case (state_r)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        state_r <= S_FREEZE;
                        core_r  <= '0;
                        idx_r   <= '0;
                    end
                end
                S_FREEZE:    if (hs) state_r <= S_MODE_UC;
                S_MODE_UC:   if (hs) state_r <= S_ROM_RD;
                S_ROM_RD:    state_r <= S_ROM_CAP;
                S_ROM_CAP: begin
                    // ROM data is valid exactly one cycle after the read.
                    instr_r <= rom_data_i;
                    state_r <= S_WR_LO;
                end
                S_WR_LO:     if (hs) state_r <= S_WR_HI;
                S_WR_HI: begin
                    if (hs) begin
                        if (idx_r == IDX_LAST) begin
                            idx_r   <= '0;
                            state_r <= S_MODE_NORM;
                        end else begin
                            idx_r   <= idx_r + idx_w'(1);
                            state_r <= S_ROM_RD;
                        end
                    end
                end
                S_MODE_NORM: if (hs) state_r <= S_UNFREEZE;
                S_UNFREEZE: begin
                    if (hs) begin
                        if (core_r == CORE_LAST) begin
                            state_r <= S_DONE;
                        end else begin
                            core_r  <= core_r + core_w'(1);
                            state_r <= S_FREEZE;
                        end
                    end
                end
                default:     state_r <= S_IDLE;
            endcase
        end
    end

    // Output decode: every field is zero unless its strobe is asserted.
    always_comb begin
        rom_v_o    = 1'b0;
        rom_addr_o = '0;
        cfg_v_o    = 1'b0;
        cfg_addr_o = '0;
        cfg_data_o = '0;
        case (state_r)
            S_FREEZE: begin
                cfg_v_o    = 1'b1;
                cfg_addr_o = ADDR_FREEZE;
                cfg_data_o = DATA_ONE;
            end
            S_MODE_UC: begin
                cfg_v_o    = 1'b1;
                cfg_addr_o = ADDR_MODE;
            end
            S_ROM_RD: begin
                rom_v_o    = 1'b1;
                rom_addr_o = idx_r;
            end
            S_WR_LO: begin
                cfg_v_o    = 1'b1;
                cfg_addr_o = ADDR_INSTR | cfg_addr_width_p'({idx_r, 1'b0});
                cfg_data_o = instr_r[cfg_data_width_p-1:0];
            end
            S_WR_HI: begin
                cfg_v_o    = 1'b1;
                cfg_addr_o = ADDR_INSTR | cfg_addr_width_p'({idx_r, 1'b1});
                cfg_data_o = instr_r[2*cfg_data_width_p-1:cfg_data_width_p];
            end
            S_MODE_NORM: begin
                cfg_v_o    = 1'b1;
                cfg_addr_o = ADDR_MODE;
                cfg_data_o = DATA_ONE;
            end
            S_UNFREEZE: begin
                cfg_v_o    = 1'b1;
                cfg_addr_o = ADDR_FREEZE;
            end
            default: ;
        endcase
    end

    assign cfg_core_o = cfg_v_o ? cfg_core_width_p'(core_r) : '0;
    assign busy_o     = (state_r != S_IDLE) && (state_r != S_DONE);
    assign done_o     = (state_r == S_DONE);

endmodule

// File: tb/tb_bp_cfg_sequencer.sv
// Directed bench for bp_cfg_sequencer: two cores, four microcode entries.
// A ROM model answers one cycle after each read and drives random data in
// every other cycle. A posedge monitor logs every accepted cfg write.
module tb_bp_cfg_sequencer;

    localparam int NC  = 2;
    localparam int ELS = 4;

    logic        clk = 1'b0;
    logic        reset_i, start_i, cfg_ready_i;
    logic        rom_v_o;
    logic [1:0]  rom_addr_o;
    logic [63:0] rom_data_i = '0;
    logic        cfg_v_o;
    logic [7:0]  cfg_core_o;
    logic [15:0] cfg_addr_o;
    logic [31:0] cfg_data_o;
    logic        busy_o, done_o;

    always #5 clk = ~clk;

    bp_cfg_sequencer #(
        .num_core_p(NC), .cfg_core_width_p(8), .cfg_addr_width_p(16),
        .cfg_data_width_p(32), .num_cce_instr_ram_els_p(ELS), .cce_instr_width_p(64)
    ) dut (
        .clk_i(clk), .reset_i(reset_i), .start_i(start_i),
        .rom_v_o(rom_v_o), .rom_addr_o(rom_addr_o), .rom_data_i(rom_data_i),
        .cfg_v_o(cfg_v_o), .cfg_core_o(cfg_core_o), .cfg_addr_o(cfg_addr_o),
        .cfg_data_o(cfg_data_o), .cfg_ready_i(cfg_ready_i),
        .busy_o(busy_o), .done_o(done_o)
    );

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0, start_cyc = 0, rom_cnt = 0, rom_dbl = 0;
    logic        rom_prev = 1'b0;
    logic [55:0] log_q[$];
    logic [55:0] exp_q[$];

    function automatic logic [63:0] rom_val(input logic [1:0] a);
        return {32'hA000_0000, 32'hB000_0000 | 32'(a)};
    endfunction

    // ROM model, cycle counter and write/read monitor.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (start_i && !busy_o && !reset_i) start_cyc <= cyc + 1;
        if (!reset_i && cfg_v_o && cfg_ready_i) log_q.push_back({cfg_core_o, cfg_addr_o, cfg_data_o});
        if (rom_v_o) rom_cnt <= rom_cnt + 1;
        if (rom_v_o && rom_prev) rom_dbl <= rom_dbl + 1;
        rom_prev   <= rom_v_o;
        rom_data_i <= rom_v_o ? rom_val(rom_addr_o) : {$urandom, $urandom};
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk) start_i = 1'b1;
        @(negedge clk) start_i = 1'b0;
    endtask

    task automatic wait_done(input int maxc, output int lat);
        lat = -1;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (done_o) begin
                lat = cyc - start_cyc;
                break;
            end
        end
    endtask

    task automatic wait_write(input logic [15:0] a, input logic [7:0] c, input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (cfg_v_o && cfg_addr_o == a && cfg_core_o == c) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Compare logged writes from index base against the first n expected ones.
    task automatic check_log(input string tag, input int base, input int n);
        chk({tag, " count"}, 64'(log_q.size() - base), 64'(n));
        for (int i = 0; i < n && base + i < log_q.size(); i++)
            chk($sformatf("%s wr%0d", tag, i), 64'(log_q[base + i]), 64'(exp_q[i]));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  lat, base, rbase;
        bit  ok;

        for (int c = 0; c < NC; c++) begin
            exp_q.push_back({8'(c), 16'h0001, 32'h1});
            exp_q.push_back({8'(c), 16'h0002, 32'h0});
            for (int i = 0; i < ELS; i++) begin
                exp_q.push_back({8'(c), 16'(16'h8000 | 2 * i),     32'hB000_0000 | 32'(i)});
                exp_q.push_back({8'(c), 16'(16'h8000 | 2 * i + 1), 32'hA000_0000});
            end
            exp_q.push_back({8'(c), 16'h0002, 32'h1});
            exp_q.push_back({8'(c), 16'h0001, 32'h0});
        end

        reset_i = 1'b1; start_i = 1'b0; cfg_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst cfg_v",  64'(cfg_v_o), 64'd0);
        chk("rst busy",   64'(busy_o), 64'd0);
        chk("rst done",   64'(done_o), 64'd0);
        chk("rst rom_v",  64'(rom_v_o), 64'd0);
        chk("rst addr",   64'(cfg_addr_o), 64'd0);
        chk("rst data",   64'(cfg_data_o), 64'd0);
        chk("rst core",   64'(cfg_core_o), 64'd0);
        reset_i = 1'b0;
        @(negedge clk);

        // Run 1: ready held high, spurious start while busy.
        base = log_q.size(); rbase = rom_cnt;
        pulse_start();
        chk("run1 busy", 64'(busy_o), 64'd1);
        repeat (5) @(negedge clk);
        pulse_start();
        wait_done(200, lat);
        chk("run1 latency", 64'(lat), 64'd40);
        check_log("run1", base, 24);
        chk("run1 rom reads", 64'(rom_cnt - rbase), 64'(NC * ELS));
        chk("run1 rom single", 64'(rom_dbl), 64'd0);
        repeat (3) @(negedge clk);
        chk("done level", 64'(done_o), 64'd1);
        chk("done busy", 64'(busy_o), 64'd0);

        // Run 2: restart from DONE with a 3-cycle stall on entry 2 high half.
        base = log_q.size(); rbase = rom_cnt;
        pulse_start();
        chk("run2 done drop", 64'(done_o), 64'd0);
        wait_write(16'h8005, 8'd0, 100, ok);
        chk("run2 reach 8005", 64'(ok), 64'd1);
        cfg_ready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("stall%0d v", k),    64'(cfg_v_o), 64'd1);
            chk($sformatf("stall%0d addr", k), 64'(cfg_addr_o), 64'h8005);
            chk($sformatf("stall%0d data", k), 64'(cfg_data_o), 64'hA000_0000);
        end
        cfg_ready_i = 1'b1;
        wait_done(200, lat);
        chk("run2 latency", 64'(lat), 64'd43);
        check_log("run2", base, 24);
        chk("run2 rom reads", 64'(rom_cnt - rbase), 64'(NC * ELS));
        chk("run2 rom single", 64'(rom_dbl), 64'd0);

        // Run 3: reset during WR_LO of entry 1, then a clean replay.
        base = log_q.size();
        pulse_start();
        wait_write(16'h8002, 8'd0, 100, ok);
        chk("run3 reach 8002", 64'(ok), 64'd1);
        reset_i = 1'b1;
        @(negedge clk);
        chk("abort cfg_v", 64'(cfg_v_o), 64'd0);
        chk("abort busy",  64'(busy_o), 64'd0);
        chk("abort done",  64'(done_o), 64'd0);
        reset_i = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort idle v", 64'(cfg_v_o), 64'd0);
        check_log("abort", base, 4);

        base = log_q.size(); rbase = rom_cnt;
        pulse_start();
        wait_done(200, lat);
        chk("run4 latency", 64'(lat), 64'd40);
        check_log("run4", base, 24);
        chk("run4 rom reads", 64'(rom_cnt - rbase), 64'(NC * ELS));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bp_cfg_sequencer.md
Name: bp_cfg_sequencer

Overview:
Boot-time configuration sequencer that drives the per-core config bus (core id / address / data) after reset.
For each core in turn it:
- freezes the core,
- puts its CCE in uncached mode,
- streams the CCE microcode from a synchronous ROM into the CCE instruction RAM,
- restores normal CCE mode,
- unfreezes the core.

It sits between the chip-level boot logic and the cfg links of the tiles. It replaces manual host-driven configuration.

Parameters:
- num_core_p, 1, number of cores to configure, in order 0..num_core_p-1.
- cfg_core_width_p, 8, width of the cfg core-id field.
- cfg_addr_width_p, 16, width of the cfg register address.
- cfg_data_width_p, 32, width of the cfg write data.
- num_cce_instr_ram_els_p, 256, number of CCE microcode entries per core (2*els <= 32768).
- cce_instr_width_p, 64, width of one microcode entry; written as two cfg_data_width_p halves.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- start_i  in  1  one-cycle pulse; begins the sequence when in IDLE or DONE
- rom_v_o  out  1  ROM read enable
- rom_addr_o  out  clog2(num_cce_instr_ram_els_p)  ROM entry index
- rom_data_i  in  cce_instr_width_p  ROM data; valid exactly one cycle after rom_v_o
- cfg_v_o  out  1  cfg write valid
- cfg_core_o  out  cfg_core_width_p  target core id
- cfg_addr_o  out  cfg_addr_width_p  target register address
- cfg_data_o  out  cfg_data_width_p  write data
- cfg_ready_i  in  1  cfg sink accepts; transfer occurs on cfg_v_o & cfg_ready_i
- busy_o  out  1  sequence in progress
- done_o  out  1  all cores configured; level signal

Behaviour:
Register map (fixed):
- 0x0001 freeze
- 0x0002 cce_mode (0 = uncached, 1 = normal)
- 0x8000 | (2*i) instr i low half, bits [31:0]
- 0x8000 | (2*i+1) instr i high half, bits [63:32]

Reset:
- State goes to IDLE; core and instr counters cleared.
- All outputs are 0 on the cycle after reset_i is sampled high.
- Reset mid-sequence aborts immediately; no further cfg writes are issued. A partially issued transfer is dropped.

States and transitions:
- IDLE: on start_i go to FREEZE with core=0, idx=0.
- FREEZE: cfg_v_o=1, addr 0x0001, data 1. On handshake go to MODE_UC.
- MODE_UC: addr 0x0002, data 0. On handshake go to ROM_RD.
- ROM_RD: rom_v_o=1, rom_addr_o=idx, cfg_v_o=0. Always advances to ROM_CAP next cycle.
- ROM_CAP: instr_r <= rom_data_i; rom_v_o=0. Advances to WR_LO.
- WR_LO: addr 0x8000|(idx<<1), data instr_r[31:0]. On handshake go to WR_HI.
- WR_HI: addr 0x8000|(idx<<1)|1, data instr_r[63:32]. On handshake:
  - if idx == els-1, clear idx and go to MODE_NORM;
  - else idx++ and go to ROM_RD.
- MODE_NORM: addr 0x0002, data 1. On handshake go to UNFREEZE.
- UNFREEZE: addr 0x0001, data 0. On handshake:
  - if core == num_core_p-1, go to DONE;
  - else core++ and go to FREEZE.
- DONE: done_o=1. On start_i, restart at FREEZE with counters cleared.

Handshake and outputs:
- While cfg_v_o=1 and cfg_ready_i=0, cfg_core_o, cfg_addr_o and cfg_data_o hold stable. cfg_v_o never deasserts without a handshake.
- cfg_core_o = core counter in every cfg-issuing state.
- cfg_addr_o and cfg_data_o are 0 when cfg_v_o=0.
- busy_o = 1 in every state except IDLE and DONE.
- start_i is ignored while busy_o=1.
- Counters never wrap: idx saturates by the transition rule above. cfg_core_o is the core counter zero-extended to cfg_core_width_p.

Minimum sequence length with cfg_ready_i held high: per core, 4 + 4*els cycles and 4 + 2*els cfg writes. done_o rises the cycle after the final UNFREEZE handshake.

Test Plan:
- num_core_p=1, els=4, ROM[i]=64'hA0000000_B000000i, ready=1, start pulse → exactly 12 writes in order:
  - (0x0001,1), (0x0002,0)
  - (0x8000,B0000000), (0x8001,A0000000), … , (0x8006,B0000003), (0x8007,A0000000)
  - (0x0002,1), (0x0001,0)
  - done_o high 20 cycles after start is sampled.
- Backpressure: cfg_ready_i low for 3 cycles during WR_HI of idx 2 → cfg_v_o, addr 0x8005 and data held constant for all 3 cycles; no duplicate or skipped write; total latency +3.
- num_core_p=2 → the 12-write sequence appears with cfg_core_o=0, then repeats with cfg_core_o=1; done_o rises only after core 1 unfreeze.
- reset_i asserted in WR_LO of idx 1 → the next cycle has cfg_v_o=0, busy_o=0, done_o=0; a new start replays from (0x0001,1) with core 0.
- start_i pulsed while busy → ignored, write count unchanged. start_i in DONE → full sequence reruns and done_o drops the cycle after.
- ROM timing: check that rom_v_o is high for exactly one cycle per entry and that the data captured is that of the cycle after rom_v_o. Drive garbage on rom_data_i in all other cycles; the written data must be unaffected.
